// File: rtl/comp_unit_seq.sv
// comp_unit_seq: byte-serial signed 32-bit comparator producing the 1-bit
// set-compare condition (SEQ/SNE/SLT/SGT/SLE/SGE) for the DLX execute stage.
// Optional build macro: COMP_EARLY_EXIT_EN. When it is defined, the unit
// finishes on the first differing byte instead of always scanning 4 bytes.
module comp_unit_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        comp_out_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_SEQ = 3'b000;
  localparam logic [2:0] OP_SNE = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b010;
  localparam logic [2:0] OP_SGT = 3'b011;
  localparam logic [2:0] OP_SLE = 3'b100;
  localparam logic [2:0] OP_SGE = 3'b101;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  idx_q, idx_d;
  logic        eq_q, eq_d;
  logic        lt_q, lt_d;
  logic        comp_q, comp_d;

  logic [7:0]  byte_a;
  logic [7:0]  byte_b;
  logic        byte_diff;
  logic        last_byte;

  // Map the final EQ/LT flags to the selected set-compare condition.
  function automatic logic compare_result(input logic [2:0] op,
                                          input logic eq, input logic lt);
    logic gt;
    gt = ~eq & ~lt;
    case (op)
      OP_SEQ:  compare_result = eq;
      OP_SNE:  compare_result = ~eq;
      OP_SLT:  compare_result = lt;
      OP_SGT:  compare_result = gt;
      OP_SLE:  compare_result = lt | eq;
      OP_SGE:  compare_result = gt | eq;
      default: compare_result = 1'b0;  // reserved encodings
    endcase
  endfunction

  // State register and datapath registers; reset aborts any in-flight op.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      comp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      comp_q  <= comp_d;
    end
  end

  // Next-state logic: accept in IDLE/DONE, scan bytes MSB-first in BUSY.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    idx_d     = idx_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    comp_d    = comp_q;
    byte_a    = a_q[{idx_q, 3'b000} +: 8];
    byte_b    = b_q[{idx_q, 3'b000} +: 8];
    byte_diff = (byte_a != byte_b);
    last_byte = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          // Flipping the sign bit turns a signed compare into an unsigned one.
          a_d     = {~a_i[31], a_i[30:0]};
          b_d     = {~b_i[31], b_i[30:0]};
          op_d    = op_i;
          idx_d   = 2'd3;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          state_d = S_BUSY;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // The first differing byte decides the ordering; later bytes are ignored.
        if (eq_q && byte_diff) begin
          eq_d = 1'b0;
          lt_d = (byte_a < byte_b);
        end
        idx_d     = idx_q - 2'd1;
        last_byte = (idx_q == 2'd0);
`ifdef COMP_EARLY_EXIT_EN
        last_byte = last_byte | (eq_q & byte_diff);
`endif
        if (last_byte) begin
          state_d = S_DONE;
          comp_d  = compare_result(op_q, eq_d, lt_d);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o     = (state_q == S_BUSY);
  assign done_o     = (state_q == S_DONE);
  assign comp_out_o = comp_q;

endmodule

// File: tb/tb_comp_unit_seq.sv
// Directed testbench for comp_unit_seq; expected latency follows the
// COMP_EARLY_EXIT_EN build macro.
module tb_comp_unit_seq;

`ifdef COMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [2:0] SEQ = 3'b000, SNE = 3'b001, SLT = 3'b010, SGT = 3'b011,
                         SLE = 3'b100, SGE = 3'b101, RS6 = 3'b110, RS7 = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, comp;

  int n_cmp = 0;
  int n_bad = 0;
  logic prev_exp = 1'b0;  // result the DUT should currently be holding

  comp_unit_seq dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .done_o     (done),
    .comp_out_o (comp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge accepts the request.
  task automatic start_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;  // operands must already be latched
    check("busy_after_accept", busy, 1);
    check("no_done_after_accept", done, 0);
    check("hold_during_busy", comp, prev_exp);
  endtask

  // Counts negedges until DONE, starting from lat0 already elapsed.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic exp_comp, input int early_lat);
    int lat;
    int exp_lat;
    exp_lat = EARLY ? early_lat : 4;
    start_op(o, av, bv);
    wait_done(0, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_comp"}, comp, exp_comp);
    check({tag, "_busy_at_done"}, busy, 0);
    prev_exp = exp_comp;
    $display("op %s: op=%b a=%h b=%h comp=%0b lat=%0d", tag, o, av, bv, comp, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int done_seen;

    // Reset held with START asserted: everything stays 0.
    rst_n = 1'b0; start = 1'b1; op = SEQ; a = 32'd5; b = 32'd5;
    repeat (3) begin
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_comp", comp, 0);
    end
    rst_n = 1'b1;
    $display("reset: busy=%0b done=%0b comp=%0b", busy, done, comp);

    do_op("seq_5_5", SEQ, 32'd5, 32'd5, 1'b1, 4);
    do_op("slt_m1_1", SLT, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1);
    do_op("sgt_m1_1", SGT, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
    @(negedge clk);
    check("idle_after_done_busy", busy, 0);
    check("idle_after_done_done", done, 0);
    do_op("sge_byte0", SGE, 32'h1234_5678, 32'h1234_5679, 1'b0, 4);
    do_op("slt_min_max", SLT, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1);
    do_op("sge_byte1", SGE, 32'h0000_0100, 32'h0000_00FF, 1'b1, 3);
    do_op("sle_m5_3", SLE, 32'hFFFF_FFFB, 32'h0000_0003, 1'b1, 1);

    // START during BUSY with different operands must be ignored.
    start_op(SNE, 32'd7, 32'd7);
    op = SLT; a = 32'd1; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat);
    check("ignore_lat", lat, 4);
    check("ignore_comp", comp, 0);
    prev_exp = 1'b0;
    $display("op ignore_start_in_busy: comp=%0b lat=%0d", comp, lat);

    // Back-to-back: accepted straight from DONE.
    do_op("sne_1_2_b2b", SNE, 32'd1, 32'd2, 1'b1, 4);
    do_op("rsv7_eq", RS7, 32'd3, 32'd3, 1'b0, 4);
    do_op("rsv6_ne", RS6, 32'd1, 32'd2, 1'b0, 4);
    do_op("sle_3_3", SLE, 32'd3, 32'd3, 1'b1, 4);

    // Abort in the second BUSY cycle.
    start_op(SEQ, 32'd5, 32'd5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_comp", comp, 0);
    prev_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_idle_comp", comp, 0);
    $display("abort: busy=%0b comp=%0b dones=%0d", busy, comp, done_seen);

    do_op("sgt_max_min", SGT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
